// File: rtl/configf_pkg.sv
// Shared types and defaults for the config command queue.
package configf_pkg;

    localparam int CFG_ADDR_W = 8;
    localparam int CFG_NUM_W  = 16;

    // Issue sequencer states: waiting for work, pulsing the host, waiting for done.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // One queued command at the default widths.
    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_NUM_W-1:0]  wrrd_num;
    } cmd_t;

endpackage

// File: rtl/configf_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is dropped and
// reported on drop; a pop while empty is ignored. DEPTH must be a power of two.
module configf_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for a push that arrives while full.
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign drop    = push && full;
    assign rdata   = mem[rptr];

    // Storage write; entries need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/configf_cmd_queue.sv
// Buffers config commands and issues them one at a time to the host stage,
// waiting for each done pulse under a watchdog. Reports dropped pushes and
// watchdog expiry as sticky errors.
module configf_cmd_queue
    import configf_pkg::*;
#(
    parameter int ADDR_W  = CFG_ADDR_W,
    parameter int NUM_W   = CFG_NUM_W,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   q_cmd_en_in,
    input  logic [ADDR_W-1:0]      q_addr_in,
    input  logic [NUM_W-1:0]       q_wrrd_num_in,
    output logic                   q_full_out,
    output logic [$clog2(DEPTH):0] q_count_out,
    output logic                   q_cmd_en_out,
    output logic [ADDR_W-1:0]      q_addr_out,
    output logic [NUM_W-1:0]       q_wrrd_num_out,
    input  logic                   q_cmd_done_in,
    output logic                   q_cmd_done_out,
    output logic                   q_busy_out,
    input  logic                   q_err_clr_in,
    output logic                   q_ovf_err_out,
    output logic                   q_tmo_err_out
);

    localparam int CMD_W = ADDR_W + NUM_W;
    // Watchdog only needs to reach TIMEOUT-1; it saturates at all-ones.
    localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
    localparam bit WD_ON = (TIMEOUT != 0);

    state_t           state;
    state_t           state_nxt;
    logic [WD_W-1:0]  wd;
    logic             wd_expired;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [CMD_W-1:0] head;
    logic             done_evt;
    logic             tmo_evt;

    configf_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (q_cmd_en_in),
        .wdata   ({q_addr_in, q_wrrd_num_in}),
        .pop     (pop),
        .rdata   (head),
        .full    (q_full_out),
        .empty   (fifo_empty),
        .count   (q_count_out),
        .drop    (fifo_drop)
    );

    assign wd_expired = WD_ON && (wd == WD_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: one issue cycle per command, then wait for done or expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (q_cmd_done_in || wd_expired) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs and events; done beats expiry in the same cycle.
    always_comb begin
        pop          = 1'b0;
        q_cmd_en_out = 1'b0;
        q_busy_out   = 1'b0;
        done_evt     = 1'b0;
        tmo_evt      = 1'b0;
        case (state)
            ST_IDLE: begin
                pop = !fifo_empty;
            end
            ST_ISSUE: begin
                q_cmd_en_out = 1'b1;
                q_busy_out   = 1'b1;
            end
            ST_WAIT: begin
                q_busy_out = 1'b1;
                done_evt   = q_cmd_done_in;
                tmo_evt    = !q_cmd_done_in && wd_expired;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // Issued command fields, captured on pop and held until the next pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_addr_out     <= '0;
            q_wrrd_num_out <= '0;
        end else if (pop) begin
            q_addr_out     <= head[CMD_W-1:NUM_W];
            q_wrrd_num_out <= head[NUM_W-1:0];
        end
    end

    // Completion pulse to the producer side, one cycle after the host's done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_cmd_done_out <= 1'b0;
        end else begin
            q_cmd_done_out <= done_evt;
        end
    end

    // Watchdog: cleared while issuing, counts (saturating) only while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd <= '0;
        end else if (state == ST_ISSUE) begin
            wd <= '0;
        end else if (state == ST_WAIT && wd != '1) begin
            wd <= wd + 1'b1;
        end
    end

    // Sticky error flags; a new error event outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_ovf_err_out <= 1'b0;
            q_tmo_err_out <= 1'b0;
        end else begin
            if (fifo_drop) begin
                q_ovf_err_out <= 1'b1;
            end else if (q_err_clr_in) begin
                q_ovf_err_out <= 1'b0;
            end
            if (tmo_evt) begin
                q_tmo_err_out <= 1'b1;
            end else if (q_err_clr_in) begin
                q_tmo_err_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_configf_cmd_queue.sv
// Bench for configf_cmd_queue: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the queue and host handshake.
module tb_configf_cmd_queue;

  localparam int ADDR_W  = 8;
  localparam int NUM_W   = 16;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              q_cmd_en_in = 1'b0;
  logic [ADDR_W-1:0] q_addr_in = '0;
  logic [NUM_W-1:0]  q_wrrd_num_in = '0;
  logic              q_full_out;
  logic [3:0]        q_count_out;
  logic              q_cmd_en_out;
  logic [ADDR_W-1:0] q_addr_out;
  logic [NUM_W-1:0]  q_wrrd_num_out;
  logic              q_cmd_done_in = 1'b0;
  logic              q_cmd_done_out;
  logic              q_busy_out;
  logic              q_err_clr_in = 1'b0;
  logic              q_ovf_err_out;
  logic              q_tmo_err_out;

  configf_cmd_queue #(
    .ADDR_W  (ADDR_W),
    .NUM_W   (NUM_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .q_cmd_en_in    (q_cmd_en_in),
    .q_addr_in      (q_addr_in),
    .q_wrrd_num_in  (q_wrrd_num_in),
    .q_full_out     (q_full_out),
    .q_count_out    (q_count_out),
    .q_cmd_en_out   (q_cmd_en_out),
    .q_addr_out     (q_addr_out),
    .q_wrrd_num_out (q_wrrd_num_out),
    .q_cmd_done_in  (q_cmd_done_in),
    .q_cmd_done_out (q_cmd_done_out),
    .q_busy_out     (q_busy_out),
    .q_err_clr_in   (q_err_clr_in),
    .q_ovf_err_out  (q_ovf_err_out),
    .q_tmo_err_out  (q_tmo_err_out)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Commands waiting in the queue, oldest first.
  logic [23:0] m_q[$];
  // Host handshake progress: 0 nothing outstanding, 1 pulse cycle, 2 awaiting done.
  int          m_phase = 0;
  int          m_waited = 0;
  logic [7:0]  e_addr = '0;
  logic [15:0] e_num = '0;
  logic        e_done = 1'b0;
  logic        e_ovf = 1'b0;
  logic        e_tmo = 1'b0;
  // Inputs that were presented to the most recent clock edge.
  logic        p_push = 1'b0;
  logic [7:0]  p_addr = '0;
  logic [15:0] p_num = '0;
  logic        p_done = 1'b0;
  logic        p_clr = 1'b0;
  // Issue-order scoreboard for the overflow scenario.
  logic [7:0]  exp_q[$];

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_waited = 0;
    e_addr = '0;
    e_num = '0;
    e_done = 1'b0;
    e_ovf = 1'b0;
    e_tmo = 1'b0;
    p_push = 1'b0;
    p_done = 1'b0;
    p_clr = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    logic        dropped;
    logic        expired;
    logic [23:0] head;
    dropped = p_push && (m_q.size() == DEPTH);
    expired = 1'b0;
    e_done = 1'b0;
    if (m_phase == 2) begin
      if (p_done) begin
        e_done = 1'b1;
        m_phase = 0;
      end else if (m_waited == TIMEOUT - 1) begin
        expired = 1'b1;
        m_phase = 0;
      end else begin
        m_waited++;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_waited = 0;
    end else if (m_q.size() > 0) begin
      head = m_q.pop_front();
      e_addr = head[23:16];
      e_num = head[15:0];
      m_phase = 1;
    end
    if (p_push && !dropped) m_q.push_back({p_addr, p_num});
    if (dropped) e_ovf = 1'b1;
    else if (p_clr) e_ovf = 1'b0;
    if (expired) e_tmo = 1'b1;
    else if (p_clr) e_tmo = 1'b0;
  endtask

  function automatic logic [33:0] exp_vec();
    logic [3:0] c;
    c = 4'(m_q.size());
    return {(m_q.size() == DEPTH), c, (m_phase == 1), e_addr, e_num, e_done,
            (m_phase != 0), e_ovf, e_tmo};
  endfunction

  function automatic logic [33:0] obs_vec();
    return {q_full_out, q_count_out, q_cmd_en_out, q_addr_out, q_wrrd_num_out,
            q_cmd_done_out, q_busy_out, q_ovf_err_out, q_tmo_err_out};
  endfunction

  // ---------------- driver ----------------
  // One cycle: at the falling edge, account for the edge just passed, then
  // present the next inputs. Outputs are stable for checking on return.
  task automatic tick(input logic push, input logic [7:0] a, input logic [15:0] n,
                      input logic done, input logic clr);
    @(negedge clk);
    model_step();
    q_cmd_en_in = push;
    q_addr_in = a;
    q_wrrd_num_in = n;
    q_cmd_done_in = done;
    q_err_clr_in = clr;
    p_push = push;
    p_addr = a;
    p_num = n;
    p_done = done;
    p_clr = clr;
  endtask

  // Bring the queue back to empty, idle, errors clear (drives only).
  task automatic settle();
    int n;
    n = 0;
    tick(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    while ((m_phase != 0 || m_q.size() != 0 || e_ovf || e_tmo) && n < 300) begin
      tick(1'b0, 8'h00, 16'h0000, m_phase == 2, 1'b1);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL settle_bound: queue did not drain, count=%0d busy=%0d", q_count_out, q_busy_out);
    end
    tick(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec() !== 34'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    settle();
    for (int i = 0; i < 14; i++) begin
      tick(i == 0, 8'h12, 16'h0004, i == 10, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (q_cmd_en_out !== 1'b0) begin
          failures++;
          $display("FAIL single_early_issue: cmd_en got %b want 0", q_cmd_en_out);
        end
      end
      if (i == 2) begin
        checks++;
        if ({q_cmd_en_out, q_addr_out, q_wrrd_num_out, q_busy_out} !== {1'b1, 8'h12, 16'h0004, 1'b1}) begin
          failures++;
          $display("FAIL single_issue: en/addr/num/busy got %b/%h/%h/%b want 1/12/0004/1",
                   q_cmd_en_out, q_addr_out, q_wrrd_num_out, q_busy_out);
        end
      end
      if (i == 11) begin
        checks++;
        if ({q_cmd_done_out, q_busy_out} !== 2'b10) begin
          failures++;
          $display("FAIL single_done: done/busy got %b/%b want 1/0", q_cmd_done_out, q_busy_out);
        end
      end
    end
  endtask

  task automatic test_timeout();
    settle();
    for (int i = 0; i < 30; i++) begin
      tick(i < 2, (i == 0) ? 8'hA1 : 8'hA2, 16'(i + 1), i == 25, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL timeout_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i >= 3 && i <= 19) begin
        checks++;
        if (q_cmd_done_out !== 1'b0) begin
          failures++;
          $display("FAIL timeout_no_done i=%0d: done got %b want 0", i, q_cmd_done_out);
        end
      end
      if (i == 18) begin
        checks++;
        if ({q_tmo_err_out, q_busy_out} !== 2'b01) begin
          failures++;
          $display("FAIL timeout_early: tmo/busy got %b/%b want 0/1", q_tmo_err_out, q_busy_out);
        end
      end
      if (i == 19) begin
        checks++;
        if ({q_tmo_err_out, q_busy_out} !== 2'b10) begin
          failures++;
          $display("FAIL timeout_flag: tmo/busy got %b/%b want 1/0", q_tmo_err_out, q_busy_out);
        end
      end
      if (i == 20) begin
        checks++;
        if ({q_cmd_en_out, q_addr_out} !== {1'b1, 8'hA2}) begin
          failures++;
          $display("FAIL timeout_next_issue: en/addr got %b/%h want 1/a2", q_cmd_en_out, q_addr_out);
        end
      end
    end
    tick(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (q_tmo_err_out !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: tmo got %b want 0", q_tmo_err_out);
    end
  endtask

  task automatic test_done_at_expiry();
    settle();
    for (int i = 0; i < 22; i++) begin
      tick(i == 0, 8'hB3, 16'h0007, i == 18, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL expiry_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 19) begin
        checks++;
        if ({q_cmd_done_out, q_tmo_err_out} !== 2'b10) begin
          failures++;
          $display("FAIL expiry_done_wins: done/tmo got %b/%b want 1/0", q_cmd_done_out, q_tmo_err_out);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [7:0] a;
    logic [7:0] want;
    for (int part = 0; part < 2; part++) begin
      settle();
      exp_q.delete();
      for (int i = 0; i < 13; i++) begin
        a = (part == 0) ? 8'(8'h91 + i) : 8'(8'hC1 + i);
        tick(i < 9 + 2 * part, a, 16'(i), 1'b0, part == 1 && (i == 10 || i == 11));
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL ovf_model p=%0d i=%0d: got %h want %h", part, i, obs_vec(), exp_vec());
        end
        if (q_cmd_en_out === 1'b1) begin
          checks++;
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          if (q_addr_out !== want) begin
            failures++;
            $display("FAIL ovf_order: issued addr %h want %h", q_addr_out, want);
          end
        end
        if (i < 9) exp_q.push_back(a);
        if (part == 0 && i == 9) begin
          checks++;
          if ({q_ovf_err_out, q_full_out, q_count_out} !== {1'b0, 1'b1, 4'd8}) begin
            failures++;
            $display("FAIL ovf_ninth_ok: ovf/full/count got %b/%b/%0d want 0/1/8",
                     q_ovf_err_out, q_full_out, q_count_out);
          end
        end
        if (part == 1 && (i == 10 || i == 11)) begin
          checks++;
          if (q_ovf_err_out !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set i=%0d: ovf got %b want 1", i, q_ovf_err_out);
          end
        end
        if (part == 1 && i == 12) begin
          checks++;
          if (q_ovf_err_out !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: ovf got %b want 0", q_ovf_err_out);
          end
        end
      end
      n = 0;
      while ((exp_q.size() != 0 || m_phase != 0) && n < 400) begin
        tick(1'b0, 8'h00, 16'h0000, m_phase == 2, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL ovf_drain_model: got %h want %h", obs_vec(), exp_vec());
        end
        if (q_cmd_en_out === 1'b1) begin
          checks++;
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          if (q_addr_out !== want) begin
            failures++;
            $display("FAIL ovf_order: issued addr %h want %h", q_addr_out, want);
          end
        end
        n++;
      end
      if (n >= 400) begin
        checks++;
        failures++;
        $display("FAIL ovf_drain_bound: %0d issues missing", exp_q.size());
      end
    end
  endtask

  task automatic test_push_pop_same_cycle();
    settle();
    for (int i = 0; i < 8; i++) begin
      tick(i < 4 || i == 5, 8'(8'hE0 + i), 16'(16'h100 + i), i == 4, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL pushpop_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 6) begin
        checks++;
        if ({q_count_out, q_cmd_en_out, q_addr_out} !== {4'd3, 1'b1, 8'hE1}) begin
          failures++;
          $display("FAIL pushpop_count: count/en/addr got %0d/%b/%h want 3/1/e1",
                   q_count_out, q_cmd_en_out, q_addr_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    settle();
    for (int i = 0; i < 5; i++) begin
      tick(i < 4, 8'(8'hD0 + i), 16'(16'h10 + i), 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rstmid_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({q_busy_out, q_count_out} !== {1'b1, 4'd3}) begin
      failures++;
      $display("FAIL rstmid_setup: busy/count got %b/%0d want 1/3", q_busy_out, q_count_out);
    end
    q_cmd_en_in = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== 34'd0) begin
      failures++;
      $display("FAIL rstmid_async: got %h want 0", obs_vec());
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
      checks++;
      if ({q_cmd_en_out, q_busy_out, q_count_out, q_cmd_done_out} !== 7'd0) begin
        failures++;
        $display("FAIL rstmid_after i=%0d: en/busy/count/done got %b/%b/%0d/%b want 0/0/0/0",
                 i, q_cmd_en_out, q_busy_out, q_count_out, q_cmd_done_out);
      end
    end
  endtask

  task automatic test_random();
    int left;
    int n;
    logic push;
    logic done;
    settle();
    left = 40;
    n = 0;
    while ((left > 0 || m_phase != 0 || m_q.size() != 0) && n < 3000) begin
      push = (left > 0) && ($urandom_range(0, 2) != 0);
      done = (m_phase == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
      tick(push, 8'($urandom), 16'($urandom), done, $urandom_range(0, 31) == 0);
      if (push) left--;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_model n=%0d: got %h want %h", n, obs_vec(), exp_vec());
      end
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL random_bound: traffic did not drain");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_done_at_expiry();
    test_overflow();
    test_push_pop_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
